// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the parameterised register file:
//     - clear_state_t : two-state clear sequencer encoding (IDLE, CLEAR)
//     - DEFAULT_DATA_WIDTH / DEFAULT_NUM_REGS : default bus width and depth
//     - addr_width_for() : address width for a given depth, never below 1 bit
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_NUM_REGS   = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clear_state_t;

   // A 2-entry file still needs one address bit, so clamp $clog2 at 1.
   function automatic int addr_width_for(input int num_regs);
      return (num_regs <= 2) ? 1 : $clog2(num_regs);
   endfunction

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// -----------------------------------------------------------------------------
// regfile_clear_seq
//   Sequencer that walks every register address once, issuing one zeroing
//   write per cycle. It starts in CLEAR out of reset, so the array (which has
//   no reset of its own) is guaranteed zero by the time busy falls.
//
//   Parameters
//     NUM_REGS   : number of registers to clear
//     ADDR_WIDTH : width of the clear address / counter
//   Ports
//     clock      in   sole clock, rising edge
//     reset_n    in   asynchronous active-low reset (restarts the sequence)
//     clear_req  in   one-cycle request to start a clear; ignored while busy
//     clear_we   out  zeroing write strobe for register[clear_addr]
//     clear_addr out  register currently being zeroed
//     busy       out  high exactly while the sequencer is in CLEAR
// -----------------------------------------------------------------------------
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int NUM_REGS   = DEFAULT_NUM_REGS,
   parameter int ADDR_WIDTH = addr_width_for(NUM_REGS)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  clear_req,
   output logic                  clear_we,
   output logic [ADDR_WIDTH-1:0] clear_addr,
   output logic                  busy
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

   clear_state_t          state;
   logic [ADDR_WIDTH-1:0] count;

   // busy is kept as its own flop, updated in step with state, so it is a
   // registered decode of CLEAR rather than combinational logic off state.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= CLEAR;
         count <= '0;
         busy  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (clear_req) begin
                  state <= CLEAR;
                  count <= '0;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               // The edge that zeroes the last register also leaves CLEAR,
               // so the sequence occupies exactly NUM_REGS cycles.
               if (count == LAST_ADDR) begin
                  state <= IDLE;
                  count <= '0;
                  busy  <= 1'b0;
               end else begin
                  count <= count + 1'b1;
               end
            end
         endcase
      end
   end

   assign clear_we   = busy;
   assign clear_addr = count;

endmodule : regfile_clear_seq

// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
//   Two-read / one-write register file with registered read ports and a
//   self-timed clear sequence (also run after every reset).
//
//   Parameters
//     DATA_WIDTH : register and bus width in bits
//     NUM_REGS   : number of registers (2..256, any value)
//     ZERO_REG   : when 1, register 0 reads as zero and ignores writes
//   Ports
//     clock            in   sole clock, rising edge
//     reset_n          in   asynchronous active-low reset
//     read_addr_a      in   port A read select
//     read_addr_b      in   port B read select
//     sig_enable_read  in   load bus_a/bus_b on the next edge; else hold
//     write_addr       in   write select
//     sig_enable_write in   write strobe
//     bus_w            in   write data
//     sig_clear        in   one-cycle request to zero every register
//     bus_a            out  registered port A read data
//     bus_b            out  registered port B read data
//     sig_busy         out  high while the clear sequence runs
//
//   Build option
//     REGFILE_WRITE_BYPASS_EN : when defined, a read of the register being
//     written in the same cycle returns bus_w instead of the old contents.
// -----------------------------------------------------------------------------
module param_register_file
   import regfile_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int NUM_REGS   = DEFAULT_NUM_REGS,
   parameter  int ZERO_REG   = 1,
   localparam int ADDR_WIDTH = addr_width_for(NUM_REGS)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] read_addr_a,
   input  logic [ADDR_WIDTH-1:0] read_addr_b,
   input  logic                  sig_enable_read,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic                  sig_enable_write,
   input  logic [DATA_WIDTH-1:0] bus_w,
   input  logic                  sig_clear,
   output logic [DATA_WIDTH-1:0] bus_a,
   output logic [DATA_WIDTH-1:0] bus_b,
   output logic                  sig_busy
);

   logic [DATA_WIDTH-1:0] mem [NUM_REGS];

   logic                  clear_we;
   logic [ADDR_WIDTH-1:0] clear_addr;
   logic                  busy;

   logic                  write_ok;
   logic [DATA_WIDTH-1:0] read_a;
   logic [DATA_WIDTH-1:0] read_b;

   // An address maps to real storage only if it is inside the array and is
   // not the hardwired zero register.
   function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] addr);
      return (int'(addr) < NUM_REGS) && !((ZERO_REG != 0) && (addr == '0));
   endfunction

   regfile_clear_seq #(
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_seq (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear_req  (sig_clear),
      .clear_we   (clear_we),
      .clear_addr (clear_addr),
      .busy       (busy)
   );

   // External writes are locked out for the whole clear sequence, so the
   // clear port and the write port never target the array in the same cycle.
   assign write_ok = sig_enable_write && !busy && addr_valid(write_addr);

   // NOTE: the array deliberately has no reset; clearing it is the job of the
   // sequencer, which keeps the storage a plain RAM-style structure.
   always_ff @(posedge clock) begin
      if (clear_we) begin
         mem[clear_addr] <= '0;
      end else if (write_ok) begin
         mem[write_addr] <= bus_w;
      end
   end

   // NOTE: combinational outputs get a default before any conditional
   // assignment so no path leaves them unassigned (which would infer a latch).
   always_comb begin
      read_a = '0;
      read_b = '0;
      if (addr_valid(read_addr_a)) begin
         read_a = mem[read_addr_a];
      end
      if (addr_valid(read_addr_b)) begin
         read_b = mem[read_addr_b];
      end
`ifdef REGFILE_WRITE_BYPASS_EN
      // Forward the in-flight write so a same-cycle read sees the new value.
      if (write_ok && (read_addr_a == write_addr)) begin
         read_a = bus_w;
      end
      if (write_ok && (read_addr_b == write_addr)) begin
         read_b = bus_w;
      end
`endif
   end

   // Reads issued during the clear sequence return zero: the array is in an
   // intermediate state and must not leak pre-clear data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus_a <= '0;
         bus_b <= '0;
      end else if (sig_enable_read) begin
         bus_a <= busy ? '0 : read_a;
         bus_b <= busy ? '0 : read_b;
      end
   end

   assign sig_busy = busy;

endmodule : param_register_file
